// File: rtl/ext_async_fifo_rd_ctrl.sv
// Read-side controller for an async FIFO: show-ahead pop into a 2-entry output
// buffer, with pause, flush-and-discard, and a saturating discarded-word count.
module ext_async_fifo_rd_ctrl #(
  parameter int FIFO_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  af_empty,
  input  logic [FIFO_WIDTH-1:0] af_rd_data,
  output logic                  af_rd_en,
  output logic [FIFO_WIDTH-1:0] af_empty_vec,
  input  logic                  enable,
  input  logic                  flush_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  flush_done,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [1:0]            count_r, count_s;
  logic [FIFO_WIDTH-1:0] buf0_r, buf1_r, buf0_s, buf1_s;
  logic [CNT_WIDTH-1:0]  drop_cnt_r, drop_cnt_s;
  logic                  pop_s, push_s, accept_s;

  assign af_empty_vec = {FIFO_WIDTH{af_empty}};
  assign af_rd_en     = pop_s;
  assign out_valid    = (count_r != 2'd0);
  assign out_data     = buf0_r;
  assign flush_done   = (state_r == ST_DONE);
  assign drop_cnt     = drop_cnt_r;

  // Next-state and pop strobe; a pending flush blocks new pops so no word is lost in the handover.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        pop_s = !rd_rst && !flush_req && !af_empty && (count_r != 2'd2);
        if (flush_req) begin
          state_s = ST_FLUSH;
        end else if (!enable) begin
          state_s = ST_PAUSE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (flush_req) begin
          state_s = ST_FLUSH;
        end else if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_FLUSH: begin
        pop_s = !rd_rst && !af_empty;
        if (af_empty && !flush_req) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        if (enable) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      default: begin
        state_s = ST_PAUSE;
      end
    endcase
  end

  assign push_s   = pop_s && (state_r == ST_RUN);
  assign accept_s = out_valid && out_ready;

  // Output buffer update: push at the tail, retire from the head, both in one cycle.
  always_comb begin
    buf0_s  = buf0_r;
    buf1_s  = buf1_r;
    count_s = count_r;
    if (state_s == ST_FLUSH) begin
      count_s = 2'd0;
    end else begin
      case ({push_s, accept_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            buf0_s = af_rd_data;
          end else begin
            buf1_s = af_rd_data;
          end
          count_s = count_r + 2'd1;
        end
        2'b01: begin
          buf0_s  = buf1_r;
          count_s = count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            buf0_s = af_rd_data;
          end else begin
            buf0_s = buf1_r;
            buf1_s = af_rd_data;
          end
        end
        default: begin
          count_s = count_r;
        end
      endcase
    end
  end

  // Discard counter sticks at all-ones instead of wrapping.
  always_comb begin
    drop_cnt_s = drop_cnt_r;
    if ((state_r == ST_FLUSH) && pop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
      drop_cnt_s = drop_cnt_r + CNT_WIDTH'(1);
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  // State, buffer and counter registers.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_r    <= ST_PAUSE;
      count_r    <= 2'd0;
      buf0_r     <= {FIFO_WIDTH{1'b0}};
      buf1_r     <= {FIFO_WIDTH{1'b0}};
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      buf0_r     <= buf0_s;
      buf1_r     <= buf1_s;
      drop_cnt_r <= drop_cnt_s;
    end
  end

endmodule

// File: tb/tb_ext_async_fifo_rd_ctrl.sv
// Directed bench for ext_async_fifo_rd_ctrl: behavioural show-ahead FIFO,
// expected-word queue checked by an independent output monitor.
module tb_ext_async_fifo_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic       af_empty;
  logic [7:0] af_rd_data;
  logic       af_rd_en;
  logic [7:0] af_empty_vec;
  logic       enable;
  logic       flush_req;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       flush_done;
  logic [2:0] drop_cnt;

  logic [7:0] mem [0:31];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       force_empty;
  int         pops = 0;
  int         fd_cnt = 0;
  int         viol = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  ext_async_fifo_rd_ctrl #(.FIFO_WIDTH(8), .CNT_WIDTH(3)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .af_empty(af_empty), .af_rd_data(af_rd_data),
    .af_rd_en(af_rd_en), .af_empty_vec(af_empty_vec), .enable(enable),
    .flush_req(flush_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush_done(flush_done), .drop_cnt(drop_cnt)
  );

  always #5 rd_clk = ~rd_clk;

  assign af_empty   = force_empty || (rd_ptr == wr_ptr);
  assign af_rd_data = mem[rd_ptr[4:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w, input bit expect_out);
    mem[wr_ptr[4:0]] = w;
    wr_ptr++;
    if (expect_out) exp_q.push_back(w);
  endtask

  task automatic wait_exp_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge rd_clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_fd(input string name, input int f0, input int budget);
    int n = 0;
    while (fd_cnt == f0 && n < budget) begin
      @(negedge rd_clk);
      n++;
    end
    check(name, fd_cnt - f0, 1);
  endtask

  // FIFO model: pop on strobe, plus pop / flush_done bookkeeping.
  always @(posedge rd_clk) begin
    if (af_rd_en) begin
      pops <= pops + 1;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
    end
    if (flush_done) fd_cnt <= fd_cnt + 1;
  end

  // Monitor: every accepted word must be the oldest outstanding expected word.
  always @(negedge rd_clk) begin
    if (af_rd_en && af_empty) viol++;
    if (out_valid && out_ready && !rd_rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no word", out_data);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    int p0, p1, f0;
    rd_rst = 1'b1; enable = 1'b0; flush_req = 1'b0; out_ready = 1'b0; force_empty = 1'b0;
    repeat (3) tick();
    @(negedge rd_clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_af_rd_en", af_rd_en, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_drop_cnt", drop_cnt, 3'd0);

    // Streaming 8 words at full rate.
    for (int i = 1; i <= 8; i++) load(8'(i), 1'b1);
    enable = 1'b1; out_ready = 1'b1;
    @(negedge rd_clk);
    check("rst_hold_no_pop", af_rd_en, 1'b0);
    tick(); rd_rst = 1'b0;
    @(negedge rd_clk);
    check("release_no_pop", af_rd_en, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      @(negedge rd_clk);
      check("stream_rd_en", af_rd_en, (k < 8) ? 1'b1 : 1'b0);
      check("stream_valid", out_valid, (k >= 1) ? 1'b1 : 1'b0);
    end
    wait_exp_empty("stream_drain", 10);

    // Backpressure: buffer fills to 2 and holds the head word.
    tick(); out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 5; i++) load(8'h11 + 8'(i), 1'b1);
    repeat (6) @(negedge rd_clk);
    check("bp_pops", pops - p0, 2);
    check("bp_valid", out_valid, 1'b1);
    check("bp_data", out_data, 8'h11);
    repeat (2) @(negedge rd_clk);
    check("bp_data_held", out_data, 8'h11);
    tick(); out_ready = 1'b1;
    wait_exp_empty("bp_drain", 30);
    check("bp_total_pops", pops - p0, 5);

    // Flush with 2 buffered and 6 in the FIFO.
    tick(); out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) load(8'h21 + 8'(i), 1'b0);
    repeat (5) @(negedge rd_clk);
    check("fl_prefill_pops", pops - p0, 2);
    tick(); flush_req = 1'b1;
    p1 = pops; f0 = fd_cnt;
    tick(); flush_req = 1'b0;
    @(negedge rd_clk);
    check("fl_valid_drop", out_valid, 1'b0);
    wait_fd("fl_done_pulse", f0, 30);
    check("fl_pops", pops - p1, 6);
    check("fl_drop_cnt", drop_cnt, 3'd6);
    repeat (3) @(negedge rd_clk);
    check("fl_single_pulse", fd_cnt - f0, 1);
    tick(); out_ready = 1'b1;
    load(8'h30, 1'b1);
    wait_exp_empty("fl_back_to_run", 10);

    // Saturation: 10 discarded words with a 3-bit counter, flush held past empty.
    tick(); rd_rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    tick(); rd_rst = 1'b0;
    @(negedge rd_clk);
    check("sat_rst_drop", drop_cnt, 3'd0);
    p0 = pops;
    for (int i = 0; i < 10; i++) load(8'h51 + 8'(i), 1'b0);
    repeat (3) @(negedge rd_clk);
    check("pause_no_pop", pops - p0, 0);
    f0 = fd_cnt;
    tick(); flush_req = 1'b1;
    repeat (15) tick();
    @(negedge rd_clk);
    check("sat_drop_cnt", drop_cnt, 3'd7);
    check("sat_pops", pops - p0, 10);
    check("flush_persists", fd_cnt - f0, 0);
    tick(); flush_req = 1'b0;
    wait_fd("sat_done_pulse", f0, 10);
    p0 = pops;
    load(8'h60, 1'b0);
    repeat (3) @(negedge rd_clk);
    check("done_to_pause", pops - p0, 0);

    // Reset mid-stream with count=2, then af_empty_vec tracking.
    tick(); enable = 1'b1;
    load(8'h61, 1'b0); load(8'h62, 1'b0);
    repeat (5) @(negedge rd_clk);
    check("mid_valid", out_valid, 1'b1);
    check("mid_data", out_data, 8'h60);
    p0 = pops;
    tick(); rd_rst = 1'b1;
    @(negedge rd_clk);
    check("mid_rst_rd_en", af_rd_en, 1'b0);
    tick();
    @(negedge rd_clk);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_rd_en2", af_rd_en, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      force_empty = (i % 2 == 0);
      #1;
      check("empty_vec", af_empty_vec, force_empty ? 8'hFF : 8'h00);
    end
    force_empty = 1'b0;
    tick(); rd_rst = 1'b0;
    @(negedge rd_clk);
    check("mid_release_pause", af_rd_en, 1'b0);
    exp_q.push_back(8'h62);
    out_ready = 1'b1;
    wait_exp_empty("mid_resume", 10);
    check("mid_rst_no_pop", pops - p0, 1);

    // Empty FIFO while enable/out_ready toggle.
    tick(); force_empty = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      tick();
      enable = (i % 3) != 0;
      out_ready = (i % 2) == 0;
    end
    @(negedge rd_clk);
    check("empty_no_pops", pops - p0, 0);
    check("never_rd_en_empty", viol, 0);
    check("sb_leftover", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_async_fifo_rd_ctrl.md
EXT_ASYNC_FIFO_RD_CTRL -- requirements
Module: ext_async_fifo_rd_ctrl

Interface
REQ-001 Parameter: FIFO_WIDTH, default 1, read-data width; any integer > 0.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the discarded-word counter.
REQ-003 Clock and reset: one clock, rd_clk (async FIFO read-clock domain); reset rd_rst is synchronous and active-high.
REQ-004 Port list, one per line: name, direction, width, meaning.
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  synchronous active-high reset.
- af_empty  in  1  async FIFO empty, already synchronized to rd_clk.
- af_rd_data  in  FIFO_WIDTH  FIFO head word, qualified with !af_empty, valid when af_empty=0 (show-ahead).
- af_rd_en  out  1  FIFO pop strobe.
- af_empty_vec  out  FIFO_WIDTH  af_empty replicated per bit; feeds the per-bit NOR qualifier gates.
- enable  in  1  1 = forward words downstream.
- flush_req  in  1  level request to discard the FIFO contents.
- out_valid  out  1  downstream word valid.
- out_ready  in  1  downstream accept.
- out_data  out  FIFO_WIDTH  downstream word.
- flush_done  out  1  one-cycle pulse when a flush completes.
- drop_cnt  out  CNT_WIDTH  saturating count of words discarded by flush.

Function
REQ-005 af_empty_vec SHALL equal {FIFO_WIDTH{af_empty}}, purely combinational, with no dependence on state or rd_rst.
REQ-006 A 2-entry in-order output buffer (count 0..2) SHALL hold popped words; out_valid = (count != 0); out_data = oldest entry.
REQ-007 FSM states: RUN, PAUSE, FLUSH, DONE.
REQ-008 RUN: af_rd_en = !af_empty && (count < 2); each popped word enters the buffer on the next rd_clk edge, so FIFO pop to out_valid latency is 1 cycle.
REQ-009 The buffer SHALL update count by +pop and -(out_valid && out_ready) in the same cycle; a simultaneous pop and accept at count=1 keeps count=1, giving 1 word/cycle sustained throughput.
REQ-010 af_rd_en SHALL never assert when af_empty=1 or count=2; the buffer SHALL never overflow or underflow.
REQ-011 out_data and out_valid SHALL be held stable while out_valid && !out_ready.
REQ-012 RUN -> PAUSE when enable=0; PAUSE forces af_rd_en=0, and buffered words remain offered downstream until accepted; PAUSE -> RUN when enable=1.
REQ-013 flush_req=1 in RUN or PAUSE -> FLUSH; flush_req has priority over enable.
REQ-014 FLUSH: the buffer is cleared on entry (out_valid=0 from the first FLUSH cycle); af_rd_en = !af_empty every cycle; every pop increments drop_cnt, which saturates at all-ones and does not wrap.
REQ-015 FLUSH -> DONE on the first cycle with af_empty=1 and flush_req=0; while flush_req=1, FLUSH persists even when the FIFO is empty.
REQ-016 DONE: flush_done=1 for exactly that one cycle, af_rd_en=0; the next state is RUN if enable=1, else PAUSE.
REQ-017 drop_cnt is cleared only by rd_rst and is not cleared by a new flush.

Reset
REQ-018 While rd_rst=1: state = PAUSE, count = 0, out_valid = 0, out_data = 0, af_rd_en = 0, flush_done = 0, drop_cnt = 0; af_empty_vec still follows af_empty.
REQ-019 rd_rst asserted mid-stream or mid-flush SHALL discard buffered words without popping, and SHALL take effect at the next rd_clk edge.
REQ-020 After rd_rst deasserts, the first possible af_rd_en is one cycle later, and only if enable=1.

Verification
REQ-021 enable=1, out_ready=1, FIFO holds 8 words (0x1..0x8), FIFO_WIDTH=8 -> 8 consecutive af_rd_en pulses, and out_data 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first pop.
REQ-022 out_ready=0 with 5 words available -> exactly 2 pops, count=2, out_data=0x1 held; raise out_ready -> 0x1..0x5 delivered in order with no loss or duplication.
REQ-023 flush_req pulsed with 2 words buffered and 6 in the FIFO -> out_valid drops the next cycle, 6 pops occur, drop_cnt=6, one flush_done pulse, then RUN.
REQ-024 CNT_WIDTH=3, flush of 10 words -> drop_cnt saturates at 7.
REQ-025 rd_rst asserted with count=2 mid-stream -> the next cycle shows out_valid=0, af_rd_en=0 and PAUSE; af_empty toggling -> af_empty_vec tracks it on every bit.
REQ-026 af_empty=1 throughout enable/out_ready toggling -> af_rd_en is never asserted (assertion checked for the whole test).
